// File: rtl/wb_master_arbiter_if.sv
// wb_master_arbiter_if: N-master request side plus single slave port of the Wishbone arbiter
//   m_cyc_i/m_stb_i/m_we_i/m_adr_i/m_dat_i/m_sel_i : packed per-master requests (master k at [k*W +: W])
//   m_ack_o/m_err_o/m_dat_o                        : per-master ack, timeout error, broadcast read data
//   s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o : slave request; s_ack_i/s_dat_i slave response
//   grant_o                                        : registered one-hot grant
//   modport slave = arbiter side, modport master = bus masters/slave environment side
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_MASTERS-1:0] m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, grant_o;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i;
  logic [DATA_WIDTH-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [ADDR_WIDTH-1:0] s_adr_o;
  logic [DATA_WIDTH/8-1:0] s_sel_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  modport slave (
    input m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: N-master -> 1-slave Wishbone classic arbiter, fixed-priority or round-robin
//   clk, reset_n (async, active-low), bus (wb_master_arbiter_if.slave: master requests, slave port, grant_o)
//   Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES stalled cycles)
module wb_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset_n,
  wb_master_arbiter_if.slave bus
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state, state_d;
  logic [NUM_MASTERS-1:0] grant, grant_d;
  logic [IW-1:0] idx, idx_d, ptr, ptr_d, win;
  logic gnt, to_hit;
  assign gnt = state == GRANTED;
  // Scan from the back so the last match written is the first in priority order.
  always_comb begin
    int c;
    c = 0;
    win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      c = ROUND_ROBIN != 0 ? (int'(ptr) + 1 + i >= NUM_MASTERS ? int'(ptr) + 1 + i - NUM_MASTERS : int'(ptr) + 1 + i) : i;
      if (bus.m_cyc_i[c]) win = IW'(c);
    end
  end
  always_comb begin
    state_d = state;
    grant_d = grant;
    idx_d = idx;
    ptr_d = ptr;
    if (!gnt && |bus.m_cyc_i) begin
      state_d = GRANTED;
      grant_d = NUM_MASTERS'(1) << win;
      idx_d = win;
      ptr_d = ROUND_ROBIN != 0 ? win : ptr;
    end else if (gnt && (!bus.m_cyc_i[idx] || to_hit)) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      idx <= '0;
      ptr <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_d;
      grant <= grant_d;
      idx <= idx_d;
      ptr <= ptr_d;
    end
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TW-1:0] cnt;
  assign to_hit = gnt && cnt == TW'(TIMEOUT_CYCLES);
  // Counter is held at zero outside a grant, so every new grant starts from zero.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (!gnt || bus.s_ack_i || to_hit) cnt <= '0;
    else if (bus.s_stb_o) cnt <= cnt + 1'b1;
`else
  assign to_hit = 1'b0;
`endif
  assign bus.grant_o = grant;
  assign bus.s_cyc_o = gnt && bus.m_cyc_i[idx] && !to_hit;
  assign bus.s_stb_o = gnt && bus.m_stb_i[idx] && !to_hit;
  assign bus.s_we_o = gnt && bus.m_we_i[idx];
  assign bus.s_adr_o = gnt ? bus.m_adr_i[idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.s_dat_o = gnt ? bus.m_dat_i[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.s_sel_o = gnt ? bus.m_sel_i[idx*SW +: SW] : '0;
  assign bus.m_ack_o = gnt && bus.s_ack_i ? grant : '0;
  assign bus.m_err_o = to_hit ? grant : '0;
  assign bus.m_dat_o = bus.s_dat_i;
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: table, directed and randomized checks of a fixed N=2 and a round-robin N=3 arbiter
module tb_wb_master_arbiter;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int passed = 0;
  int own[2];
  int ptr[2];
  int stall[2];
  int nm[2] = '{2, 3};
  int rr[2] = '{0, 1};
  typedef struct {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic ack;
    logic [1:0] grant;
    logic s_cyc;
    logic [1:0] ack_o;
  } vec_t;
  vec_t tab[16];
  always #5 clk = ~clk;
  wb_master_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) a ();
  wb_master_arbiter_if #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) b ();
  wb_master_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(4))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(a));
  wb_master_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(b));
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    a.m_cyc_i = '0; a.m_stb_i = '0; a.m_we_i = '0; a.m_adr_i = '0;
    a.m_dat_i = '0; a.m_sel_i = '0; a.s_ack_i = 1'b0; a.s_dat_i = '0;
    b.m_cyc_i = '0; b.m_stb_i = '0; b.m_we_i = '0; b.m_adr_i = '0;
    b.m_dat_i = '0; b.m_sel_i = '0; b.s_ack_i = 1'b0; b.s_dat_i = '0;
  endtask
  // Reference: owner (-1 = nobody), last granted channel, stalled-beat count.
  task automatic mdl_step(int d, logic [2:0] cyc, logic [2:0] stb, logic ack);
    if (own[d] >= 0) begin
      if ((TO > 0 && stall[d] == TO) || !cyc[own[d]]) own[d] = -1;
      else if (ack) stall[d] = 0;
      else if (stb[own[d]]) stall[d]++;
    end else begin
      for (int k = 1; k <= nm[d]; k++) begin
        int c;
        c = rr[d] != 0 ? (ptr[d] + k) % nm[d] : k - 1;
        if (own[d] < 0 && cyc[c]) begin
          own[d] = c;
          stall[d] = 0;
          if (rr[d] != 0) ptr[d] = c;
        end
      end
    end
  endtask
  function automatic logic [127:0] exp_ctrl(int o, int st, logic [2:0] cyc, logic [2:0] stb, logic [2:0] we, logic ack);
    logic to;
    logic [2:0] oh;
    to = TO > 0 && o >= 0 && st == TO;
    oh = o >= 0 ? 3'(1 << o) : 3'b0;
    return {116'b0, oh, ack ? oh : 3'b0, to ? oh : 3'b0, |(cyc & oh) && !to, |(stb & oh) && !to, |(we & oh)};
  endfunction
  function automatic logic [127:0] exp_data(int o, logic [95:0] adr, logic [95:0] dat, logic [11:0] sel, logic [31:0] sdat);
    int oo;
    oo = o < 0 ? 0 : o;
    return {28'b0, o < 0 ? 32'b0 : adr[oo*32 +: 32], o < 0 ? 32'b0 : dat[oo*32 +: 32], o < 0 ? 4'b0 : sel[oo*4 +: 4], sdat};
  endfunction
  task automatic rr_txn(int n, logic [2:0] req, int exp);
    logic [2:0] oh;
    oh = 3'(1 << exp);
    nxt(); b.m_cyc_i = req; b.m_stb_i = req; b.s_ack_i = 1'b0;
    @(negedge clk); chk($sformatf("rr%0d idle grant", n), b.grant_o, 0);
    nxt(); b.s_ack_i = 1'b1;
    @(negedge clk); chk($sformatf("rr%0d grant", n), b.grant_o, oh);
    chk($sformatf("rr%0d ack", n), b.m_ack_o, oh);
    nxt(); b.s_ack_i = 1'b0; b.m_cyc_i = req & ~oh; b.m_stb_i = req & ~oh;
    @(negedge clk); chk($sformatf("rr%0d drop s_cyc", n), b.s_cyc_o, 0);
  endtask
  initial begin
    tab[0] = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tab[1] = '{2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tab[2] = '{2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    tab[3] = '{2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00};
    tab[4] = '{2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
    tab[5] = '{2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 2'b10};
    tab[6] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    tab[7] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
    tab[8] = '{2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00};
    tab[9] = '{2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 2'b00};
    tab[10] = '{2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tab[11] = '{2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    tab[12] = '{2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00};
    tab[13] = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 2'b00};
    tab[14] = '{2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
    tab[15] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    clr();
    a.m_cyc_i = 2'b11; a.m_stb_i = 2'b11; a.s_ack_i = 1'b1;
    b.m_cyc_i = 3'b111; b.m_stb_i = 3'b111;
    #1;
    chk("reset s_cyc", a.s_cyc_o, 0);
    chk("reset grant", a.grant_o, 0);
    chk("reset ack", a.m_ack_o, 0);
    @(negedge clk);
    @(negedge clk);
    chk("reset held grant", {a.grant_o, b.grant_o, b.s_cyc_o}, 0);
    clr();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nxt();
      a.m_cyc_i = tab[i].cyc; a.m_stb_i = tab[i].stb; a.s_ack_i = tab[i].ack;
      @(negedge clk);
      chk($sformatf("tab%0d grant", i), a.grant_o, tab[i].grant);
      chk($sformatf("tab%0d s_cyc", i), a.s_cyc_o, tab[i].s_cyc);
      chk($sformatf("tab%0d ack", i), a.m_ack_o, tab[i].ack_o);
    end
    nxt(); a.m_cyc_i = 2'b10; a.m_stb_i = 2'b10; a.m_adr_i = {32'h8000_0004, 32'hdead_beef};
    @(negedge clk); chk("rd latency s_cyc", a.s_cyc_o, 0);
    nxt();
    @(negedge clk); chk("rd s_cyc", a.s_cyc_o, 1);
    chk("rd s_adr", a.s_adr_o, 32'h8000_0004);
    chk("rd grant", a.grant_o, 2'b10);
    chk("rd we", a.s_we_o, 0);
    nxt();
    @(negedge clk); chk("rd wait ack", a.m_ack_o, 0);
    nxt(); a.s_ack_i = 1'b1; a.s_dat_i = 32'h1234_5678;
    @(negedge clk); chk("rd ack", a.m_ack_o, 2'b10);
    chk("rd data", a.m_dat_o, 32'h1234_5678);
    nxt(); clr();
    nxt();
    rr_txn(0, 3'b011, 0);
    rr_txn(1, 3'b011, 1);
    rr_txn(2, 3'b011, 0);
    rr_txn(3, 3'b011, 1);
    rr_txn(4, 3'b111, 2);
    rr_txn(5, 3'b111, 0);
    rr_txn(6, 3'b111, 1);
    rr_txn(7, 3'b111, 2);
    nxt(); clr();
    nxt();
    nxt(); b.m_cyc_i = 3'b001; b.m_stb_i = 3'b001; b.m_we_i = 3'b001; b.m_adr_i = 96'h40;
    nxt(); b.s_ack_i = 1'b1;
    @(negedge clk); chk("wr beat1 grant", b.grant_o, 3'b001);
    chk("wr beat1 ack", b.m_ack_o, 3'b001);
    nxt(); b.m_adr_i = 96'h44;
    #2; chk("wr beat2 ack", b.m_ack_o, 3'b001);
    reset_n = 1'b0;
    #1; chk("async reset outs", {b.s_cyc_o, b.s_stb_o, b.s_we_o, b.grant_o, b.m_ack_o, b.s_adr_o}, 0);
    clr();
    @(negedge clk); reset_n = 1'b1;
    nxt(); b.m_cyc_i = 3'b111; b.m_stb_i = 3'b111;
    @(negedge clk); chk("post reset latency", b.grant_o, 0);
    nxt();
    @(negedge clk); chk("post reset ptr grant", b.grant_o, 3'b001);
    nxt(); clr();
    nxt();
    nxt(); a.m_cyc_i = 2'b01; a.m_stb_i = 2'b01;
    @(negedge clk); chk("to first grant", a.grant_o, 0);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      nxt();
      @(negedge clk);
      chk($sformatf("to s_cyc k%0d", k), a.s_cyc_o, k < 5);
      chk($sformatf("to err k%0d", k), a.m_err_o, k < 5 ? 2'b00 : 2'b01);
    end
    nxt();
    @(negedge clk); chk("to idle grant", a.grant_o, 0);
    chk("to idle err", a.m_err_o, 0);
    nxt();
    @(negedge clk); chk("to regrant", a.grant_o, 2'b01);
`else
    repeat (120) nxt();
    @(negedge clk); chk("hold grant", a.grant_o, 2'b01);
    chk("hold s_cyc", a.s_cyc_o, 1);
    chk("hold err", a.m_err_o, 0);
`endif
    nxt(); clr();
    @(negedge clk); reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      own[d] = -1;
      ptr[d] = nm[d] - 1;
      stall[d] = 0;
    end
    @(negedge clk); reset_n = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      mdl_step(0, 3'(a.m_cyc_i), 3'(a.m_stb_i), a.s_ack_i);
      mdl_step(1, b.m_cyc_i, b.m_stb_i, b.s_ack_i);
      #1;
      for (int i = 0; i < 2; i++) begin
        a.m_cyc_i[i] = a.m_cyc_i[i] ^ ($urandom_range(3) == 0);
        a.m_stb_i[i] = $urandom_range(3) != 0;
        a.m_we_i[i] = $urandom_range(1) == 1;
      end
      for (int i = 0; i < 3; i++) begin
        b.m_cyc_i[i] = b.m_cyc_i[i] ^ ($urandom_range(3) == 0);
        b.m_stb_i[i] = $urandom_range(3) != 0;
        b.m_we_i[i] = $urandom_range(1) == 1;
      end
      a.m_adr_i = {$urandom, $urandom}; a.m_dat_i = {$urandom, $urandom}; a.m_sel_i = 8'($urandom);
      b.m_adr_i = {$urandom, $urandom, $urandom}; b.m_dat_i = {$urandom, $urandom, $urandom}; b.m_sel_i = 12'($urandom);
      a.s_ack_i = $urandom_range(2) == 0; a.s_dat_i = $urandom;
      b.s_ack_i = $urandom_range(2) == 0; b.s_dat_i = $urandom;
      @(negedge clk);
      chk($sformatf("rand_a ctrl t%0d", t),
          {116'b0, 3'(a.grant_o), 3'(a.m_ack_o), 3'(a.m_err_o), a.s_cyc_o, a.s_stb_o, a.s_we_o},
          exp_ctrl(own[0], stall[0], 3'(a.m_cyc_i), 3'(a.m_stb_i), 3'(a.m_we_i), a.s_ack_i));
      chk($sformatf("rand_a data t%0d", t), {28'b0, a.s_adr_o, a.s_dat_o, a.s_sel_o, a.m_dat_o},
          exp_data(own[0], 96'(a.m_adr_i), 96'(a.m_dat_i), 12'(a.m_sel_i), a.s_dat_i));
      chk($sformatf("rand_b ctrl t%0d", t),
          {116'b0, b.grant_o, b.m_ack_o, b.m_err_o, b.s_cyc_o, b.s_stb_o, b.s_we_o},
          exp_ctrl(own[1], stall[1], b.m_cyc_i, b.m_stb_i, b.m_we_i, b.s_ack_i));
      chk($sformatf("rand_b data t%0d", t), {28'b0, b.s_adr_o, b.s_dat_o, b.s_sel_o, b.m_dat_o},
          exp_data(own[1], b.m_adr_i, b.m_dat_i, b.m_sel_i, b.s_dat_i));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
